// File: rtl/hex_display_sched.sv
// hex_display_sched: time-shares one nibble decoder across NUM_DIGITS digits with write arbitration and periodic refresh
module hex_display_sched #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_wr_en,
  input  logic [4*NUM_DIGITS-1:0] cpu_wr_data,
  input  logic                    dbg_wr_en,
  input  logic [4*NUM_DIGITS-1:0] dbg_wr_data,
  input  logic                    dbg_override,
  input  logic [NUM_DIGITS-1:0]   digit_blank,
  output logic [3:0]              nibble,
  input  logic [6:0]              hex_in,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic                    busy,
  output logic                    refresh_done
);
  localparam int VW = 4*NUM_DIGITS;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]              state_q, state_d;
  logic [VW-1:0]           value_q, value_d, work_q, work_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    pending_q, pending_d;
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
  logic                    wr_acc, wrap, start, last;
  assign wr_acc       = dbg_wr_en | (cpu_wr_en & ~dbg_override);
  assign wrap         = cnt_q == CW'(REFRESH_DIV-1);
  assign start        = (state_q == IDLE) & pending_q;
  assign last         = idx_q == IW'(NUM_DIGITS-1);
  assign nibble       = state_q == SCAN ? work_q[{idx_q, 2'b00} +: 4] : 4'h0;
  assign busy         = state_q != IDLE;
  assign refresh_done = state_q == DONE;
  assign hex_out      = hex_q;
  // each digit latches the decoder output only on its own SCAN slot; blanking forces it dark
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    assign hex_d[7*i +: 7] = (state_q == SCAN && idx_q == IW'(i)) ? (digit_blank[i] ? 7'h7F : hex_in) : hex_q[7*i +: 7];
  end
  // next-state: debug beats CPU, and a write or wrap coinciding with sweep start keeps pending set
  always_comb begin
    value_d   = dbg_wr_en ? dbg_wr_data : (cpu_wr_en & ~dbg_override) ? cpu_wr_data : value_q;
    pending_d = wr_acc | wrap | (pending_q & ~start);
    cnt_d     = wrap ? '0 : cnt_q + 1'b1;
    work_d    = start ? value_q : work_q;
    idx_d     = state_q == SCAN ? idx_q + 1'b1 : '0;
    state_d   = state_q == IDLE ? (pending_q ? SCAN : IDLE) : state_q == SCAN ? (last ? DONE : SCAN) : IDLE;
  end
  // state registers; reset darkens every digit and schedules an initial sweep of zeros
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      value_q   <= '0;
      work_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b1;
      hex_q     <= {NUM_DIGITS{7'h7F}};
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      work_q    <= work_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      hex_q     <= hex_d;
    end
  end
endmodule

// File: tb/tb_hex_display_sched.sv
// tb_hex_display_sched: directed checks of the shared-decoder display sequencer
module tb_hex_display_sched;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_wr_en = 1'b0;
  logic [15:0] cpu_wr_data = '0;
  logic        dbg_wr_en = 1'b0;
  logic [15:0] dbg_wr_data = '0;
  logic        dbg_override = 1'b0;
  logic [3:0]  digit_blank = '0;
  logic [3:0]  nibble;
  logic [6:0]  hex_in;
  logic [27:0] hex_out;
  logic        busy, refresh_done;
  int total = 0, bad = 0, rd_cnt = 0, busy_cnt = 0;
  bit seen;

  hex_display_sched #(.NUM_DIGITS(4), .REFRESH_DIV(1024)) dut (
    .clk(clk), .reset(reset), .cpu_wr_en(cpu_wr_en), .cpu_wr_data(cpu_wr_data),
    .dbg_wr_en(dbg_wr_en), .dbg_wr_data(dbg_wr_data), .dbg_override(dbg_override),
    .digit_blank(digit_blank), .nibble(nibble), .hex_in(hex_in), .hex_out(hex_out),
    .busy(busy), .refresh_done(refresh_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction
  assign hex_in = seg(nibble);

  task automatic tick();
    @(posedge clk);
    #1;
    if (refresh_done) rd_cnt++;
    if (busy) busy_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    ticks(2);
    chk("reset_hex", {4'h0, hex_out}, {4'h0, {4{7'h7F}}});
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_rd", {31'h0, refresh_done}, 32'h0);
    chk("reset_nibble", {28'h0, nibble}, 32'h0);
    reset = 1'b0;
    rd_cnt = 0;
    ticks(6);
    chk("init_hex", {4'h0, hex_out}, {4'h0, {4{7'h40}}});
    chk("init_rd_pulses", rd_cnt, 1);
    chk("init_idle", {31'h0, busy}, 32'h0);

    cpu_wr_en = 1'b1; cpu_wr_data = 16'h1234;
    tick();
    cpu_wr_en = 1'b0;
    ticks(4);
    chk("cpu_e4_digit3_old", {4'h0, hex_out}, {4'h0, 7'h40, 7'h24, 7'h30, 7'h19});
    tick();
    chk("cpu_e5_hex", {4'h0, hex_out}, {4'h0, 7'h79, 7'h24, 7'h30, 7'h19});
    chk("cpu_e5_rd", {31'h0, refresh_done}, 32'h1);
    tick();

    cpu_wr_en = 1'b1; cpu_wr_data = 16'hAAAA;
    dbg_wr_en = 1'b1; dbg_wr_data = 16'h5B0C;
    tick();
    cpu_wr_en = 1'b0; dbg_wr_en = 1'b0;
    ticks(6);
    chk("simul_dbg_wins", {4'h0, hex_out}, {4'h0, 7'h12, 7'h03, 7'h40, 7'h46});

    dbg_override = 1'b1;
    cpu_wr_en = 1'b1; cpu_wr_data = 16'hFFFF;
    busy_cnt = 0;
    tick();
    cpu_wr_en = 1'b0;
    ticks(20);
    chk("override_no_sweep", busy_cnt, 0);
    chk("override_hex", {4'h0, hex_out}, {4'h0, 7'h12, 7'h03, 7'h40, 7'h46});
    dbg_override = 1'b0;

    cpu_wr_en = 1'b1; cpu_wr_data = 16'h0000;
    tick();
    cpu_wr_en = 1'b0;
    tick();
    cpu_wr_en = 1'b1; cpu_wr_data = 16'hDEAD;
    tick();
    cpu_wr_en = 1'b0;
    ticks(3);
    chk("mid_first_hex", {4'h0, hex_out}, {4'h0, {4{7'h40}}});
    chk("mid_first_rd", {31'h0, refresh_done}, 32'h1);
    tick();
    chk("mid_gap_idle", {31'h0, busy}, 32'h0);
    tick();
    chk("mid_second_nib0", {28'h0, nibble}, 32'hD);
    ticks(4);
    chk("mid_second_hex", {4'h0, hex_out}, {4'h0, 7'h21, 7'h06, 7'h08, 7'h21});
    chk("mid_second_rd", {31'h0, refresh_done}, 32'h1);
    tick();

    digit_blank = 4'b0101;
    seen = 1'b0;
    for (int i = 0; i < 1024 + 6 && !seen; i++) begin
      tick();
      seen = refresh_done;
    end
    chk("refresh_seen", {31'h0, seen}, 32'h1);
    chk("blank_hex", {4'h0, hex_out}, {4'h0, 7'h21, 7'h7F, 7'h08, 7'h7F});

    digit_blank = 4'b0000;
    cpu_wr_en = 1'b1; cpu_wr_data = 16'h1234;
    tick();
    cpu_wr_en = 1'b0;
    ticks(3);
    chk("prereset_partial", {4'h0, hex_out}, {4'h0, 7'h21, 7'h7F, 7'h30, 7'h19});
    reset = 1'b1;
    #1;
    chk("midscan_reset_hex", {4'h0, hex_out}, {4'h0, {4{7'h7F}}});
    chk("midscan_reset_busy", {31'h0, busy}, 32'h0);
    tick();
    reset = 1'b0;
    ticks(6);
    chk("after_reset_zeros", {4'h0, hex_out}, {4'h0, {4{7'h40}}});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hex_display_sched.md
# hex_display_sched

Sequencer that shares one combinational nibble-to-seven-segment decoder across NUM_DIGITS display digits. It arbitrates display-value writes between the CPU and the debug port. On a new value or a periodic refresh tick, it scans the held value one nibble per cycle through the decoder and latches each decoded pattern into a per-digit segment register. It sits between the LC-3 I/O write path and the board's HEX outputs.

## Interface
- NUM_DIGITS, 4, number of digits scanned; the value width is 4*NUM_DIGITS.
- REFRESH_DIV, 1024, cycles between periodic refresh requests (≥ NUM_DIGITS+2).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high.
- cpu_wr_en  in  1  CPU write strobe (requester 0).
- cpu_wr_data  in  4*NUM_DIGITS  CPU value.
- dbg_wr_en  in  1  debug write strobe (requester 1).
- dbg_wr_data  in  4*NUM_DIGITS  debug value.
- dbg_override  in  1  debug owns the display; CPU writes are ignored while high.
- digit_blank  in  NUM_DIGITS  bit i=1 blanks digit i; sampled when digit i is latched.
- nibble  out  4  drive to the shared decoder input.
- hex_in  in  7  decoder output, active-low segments, same-cycle combinational.
- hex_out  out  7*NUM_DIGITS  latched segments; digit i at [7i+6:7i].
- busy  out  1  high in SCAN and DONE.
- refresh_done  out  1  one-cycle pulse after a sweep completes.

## Operation
- Single value register `value`. Write arbitration is evaluated each edge:
  - dbg_wr_en=1 → value <= dbg_wr_data.
  - else cpu_wr_en=1 and dbg_override=0 → value <= cpu_wr_data.
  - else hold.
- Simultaneous dbg and cpu writes: debug wins and the CPU write is dropped, with no retry.
- Any accepted write sets `pending`.
- Refresh counter runs 0..REFRESH_DIV-1 and wraps. At the wrap edge it sets `pending`.
- FSM states:
  - IDLE: nibble=0. If pending=1: work <= value, idx <= 0, clear pending, go to SCAN.
  - SCAN: nibble = work[4*idx+3:4*idx]. On each edge: hex_out digit idx <= digit_blank[idx] ? 7'h7F : hex_in, and idx++. After latching idx=NUM_DIGITS-1, go to DONE.
  - DONE: refresh_done=1 for one cycle, then go to IDLE.
- Conflict resolution: if an accepted write or refresh wrap lands on the same edge that clears pending, pending stays 1. The sweep uses the old value and another sweep follows.
- Writes during SCAN/DONE update `value` and set `pending` only. `work` is frozen, so the sweep in progress is never torn.
- Reset values:
  - hex_out all 7'h7F (dark), nibble 0, busy 0, refresh_done 0.
  - value 0, pending 1, refresh counter 0, state IDLE.
  - The first sweep after reset therefore displays all zeros.
- Reset asserted mid-scan aborts immediately to the reset values above. Partially latched digits return to dark.

## Timing
- An accepted write sampled at edge E0 means:
  - E1: IDLE→SCAN.
  - E2: digit 0 latched.
  - E(NUM_DIGITS+1): last digit latched.
  - refresh_done high between E(NUM_DIGITS+1) and E(NUM_DIGITS+2).
  - Write-to-last-digit latency is NUM_DIGITS+1 cycles.
- Back-to-back sweeps: DONE→IDLE→SCAN costs 2 cycles between sweeps.
- Sweep length is NUM_DIGITS+1 cycles (SCAN+DONE). Throughput is at most one value per NUM_DIGITS+2 cycles. Intermediate writes collapse to the latest value.
- hex_out changes only on SCAN edges, one digit per edge, in order 0..NUM_DIGITS-1.
- digit_blank changes show up at the next sweep, which is at most REFRESH_DIV+NUM_DIGITS+2 cycles later.

## Test plan
The bench instantiates the team's nibble decoder between nibble and hex_in.

- **Reset:** assert reset, release, wait 6 cycles → hex_out all 7'h7F during reset, then 0x40 on all four digits; one refresh_done pulse.
- **CPU write:** cpu_wr_data=16'h1234 → digits 0..3 = 0x19, 0x30, 0x24, 0x79; digit 3 latched 5 cycles after the write edge.
- **Simultaneous writes:** cpu_wr_data=16'hAAAA and dbg_wr_data=16'h5B0C on the same cycle with dbg_override=0 → digits 0..3 = 0x46, 0x40, 0x03, 0x12.
- **Override:** dbg_override=1, cpu_wr_data=16'hFFFF → ignored; display unchanged and no sweep until the refresh wrap.
- **Write mid-sweep:** write 16'h0000, then 16'hDEAD two cycles later → first sweep completes as 0x40×4 with refresh_done; a second sweep follows 2 cycles later ending 0x21, 0x08, 0x06, 0x21.
- **Blank and refresh:** set digit_blank=4'b0101 with no write → within REFRESH_DIV+6 cycles digits 0 and 2 read 7'h7F and digits 1 and 3 are unchanged. Separately, assert reset mid-SCAN → all digits 7'h7F immediately.
